// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: pulses the PLL reset, waits for a stable lock with timeout/retry,
// then releases the core reset; counts lock losses seen while running.
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       clear_error,
  output logic       pll_rst,
  output logic       core_reset_n,
  output logic       locked_ok,
  output logic       timeout_error,
  output logic [1:0] retry_count,
  output logic [7:0] lost_count
);
  localparam int MAX_A = RST_CYCLES > LOCK_TIMEOUT ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C = MAX_A > STABLE_CYCLES ? MAX_A : STABLE_CYCLES;
  localparam int CW = $clog2(MAX_C) + 1;

  typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAIL} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    retry_q, retry_d;
  logic [7:0]    lost_q, lost_d;
  logic [1:0]    sync_q;
  logic          pll_rst_q, core_reset_n_q, locked_ok_q, timeout_error_q;
  logic          lk;

  // pll_locked is asynchronous to clk; every decision uses the synchronized copy
  assign lk = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    retry_d = retry_q;
    lost_d  = lost_q;
    case (state_q)
      RESET_PLL:
        if (cnt_q == CW'(RST_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      WAIT_LOCK:
        if (lk) begin
          state_d = STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          cnt_d = '0;
          if (retry_q == 2'(MAX_RETRIES - 1)) state_d = FAIL;
          else begin
            retry_d = retry_q + 2'd1;
            state_d = RESET_PLL;
          end
        end
      STABILIZE:
        if (!lk) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
          retry_d = '0;
        end
      RUN: begin
        cnt_d = '0;
        if (!lk) begin
          state_d = RESET_PLL;
          lost_d  = lost_q + {7'd0, ~&lost_q};
        end
      end
      FAIL: begin
        cnt_d = '0;
        if (clear_error) begin
          state_d = RESET_PLL;
          retry_d = '0;
          lost_d  = '0;
        end
      end
      default: begin
        state_d = RESET_PLL;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= RESET_PLL;
      cnt_q           <= '0;
      retry_q         <= '0;
      lost_q          <= '0;
      sync_q          <= '0;
      pll_rst_q       <= 1'b1;
      core_reset_n_q  <= 1'b0;
      locked_ok_q     <= 1'b0;
      timeout_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      retry_q         <= retry_d;
      lost_q          <= lost_d;
      sync_q          <= {sync_q[0], pll_locked};
      pll_rst_q       <= state_d == RESET_PLL || state_d == FAIL;
      core_reset_n_q  <= state_d == RUN;
      locked_ok_q     <= state_d == RUN;
      timeout_error_q <= state_d == FAIL;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign core_reset_n  = core_reset_n_q;
  assign locked_ok     = locked_ok_q;
  assign timeout_error = timeout_error_q;
  assign retry_count   = retry_q;
  assign lost_count    = lost_q;
endmodule
